// File: rtl/snitch_icache_data_arbiter.sv
// Instruction-cache data bank access controller.
// Arbitrates lookup reads (all ways in parallel) against refill writes (one
// way), drives the SRAM pins and owns the read-response path. A one-entry
// buffer catches SRAM data when the response consumer stalls, so a read
// grant never loses data.
module snitch_icache_data_arbiter #(
  parameter int unsigned SET_COUNT     = 8,
  parameter int unsigned LINE_WIDTH    = 128,
  parameter int unsigned LINE_COUNT    = 128,
  parameter int unsigned MAX_WR_STREAK = 4,
  // Derived widths; not meant to be overridden.
  parameter int unsigned COUNT_ALIGN   = $clog2(LINE_COUNT),
  parameter int unsigned SET_ALIGN     = (SET_COUNT > 1) ? $clog2(SET_COUNT) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  // lookup read request
  input  logic                            lookup_valid_i,
  output logic                            lookup_ready_o,
  input  logic [COUNT_ALIGN-1:0]          lookup_addr_i,
  // read response, all ways
  output logic                            rsp_valid_o,
  input  logic                            rsp_ready_i,
  output logic [SET_COUNT*LINE_WIDTH-1:0] rsp_data_o,
  // refill write request
  input  logic                            write_valid_i,
  output logic                            write_ready_o,
  input  logic [COUNT_ALIGN-1:0]          write_addr_i,
  input  logic [SET_ALIGN-1:0]            write_set_i,
  input  logic [LINE_WIDTH-1:0]           write_data_i,
  // SRAM bank
  output logic [SET_COUNT-1:0]            ram_enable_o,
  output logic                            ram_write_o,
  output logic [COUNT_ALIGN-1:0]          ram_addr_o,
  output logic [SET_COUNT*LINE_WIDTH-1:0] ram_wdata_o,
  input  logic [SET_COUNT*LINE_WIDTH-1:0] ram_rdata_i
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_WR_STREAK);

  logic                            rd_inflight;
  logic                            buf_valid;
  logic [SET_COUNT*LINE_WIDTH-1:0] buf_q;
  logic [3:0]                      wr_streak;

  logic                 read_ok;
  logic                 streak_full;
  logic                 read_gnt;
  logic                 write_gnt;
  logic [SET_COUNT-1:0] set_onehot;

  assign rsp_valid_o = rd_inflight | buf_valid;
  assign rsp_data_o  = buf_valid ? buf_q : ram_rdata_i;
  assign read_ok     = !rsp_valid_o | rsp_ready_i;
  assign streak_full = (wr_streak == STREAK_MAX);

  // Each ready is built only from the other side's valid, so neither
  // handshake loops back through its own valid.
  assign lookup_ready_o = !rst_i & read_ok & (!write_valid_i | streak_full);
  assign write_ready_o  = !rst_i & !(lookup_valid_i & read_ok & streak_full);
  assign read_gnt       = lookup_valid_i & lookup_ready_o;
  assign write_gnt      = write_valid_i & write_ready_o;

  assign ram_wdata_o = {SET_COUNT{write_data_i}};

  // Decode target way; an out-of-range way selects nothing.
  always_comb begin
    set_onehot = '0;
    for (int unsigned s = 0; s < SET_COUNT; s++) begin
      set_onehot[s] = (write_set_i == SET_ALIGN'(s));
    end
  end

  // Drive the SRAM pins from whichever request won this cycle.
  always_comb begin
    ram_enable_o = '0;
    ram_write_o  = 1'b0;
    ram_addr_o   = '0;
    if (read_gnt) begin
      ram_enable_o = '1;
      ram_addr_o   = lookup_addr_i;
    end else if (write_gnt) begin
      ram_enable_o = set_onehot;
      ram_write_o  = 1'b1;
      ram_addr_o   = write_addr_i;
    end
  end

  // Track the outstanding read and capture its data when the consumer stalls.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_inflight <= 1'b0;
      buf_valid   <= 1'b0;
      buf_q       <= '0;
    end else begin
      rd_inflight <= read_gnt;
      if (rd_inflight && !rsp_ready_i) begin
        buf_valid <= 1'b1;
        buf_q     <= ram_rdata_i;
      end else if (buf_valid && rsp_ready_i) begin
        buf_valid <= 1'b0;
      end
    end
  end

  // Count writes that overtook a grantable read; a read or an idle lookup
  // port clears the count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_streak <= '0;
    end else if (!lookup_valid_i || read_gnt) begin
      wr_streak <= '0;
    end else if (write_gnt && read_ok && !streak_full) begin
      wr_streak <= wr_streak + 4'd1;
    end
  end

endmodule

// File: tb/tb_snitch_icache_data_arbiter.sv
// Directed bench for the icache data arbiter with a behavioural SRAM bank.
module tb_snitch_icache_data_arbiter;

  localparam int SC = 8;
  localparam int LW = 128;
  localparam int LC = 128;
  localparam int DW = SC * LW;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          lookup_valid, lookup_ready;
  logic [6:0]    lookup_addr;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          write_valid, write_ready;
  logic [6:0]    write_addr;
  logic [2:0]    write_set;
  logic [LW-1:0] write_data;
  logic [SC-1:0] ram_enable;
  logic          ram_write;
  logic [6:0]    ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  snitch_icache_data_arbiter #(
    .SET_COUNT(SC), .LINE_WIDTH(LW), .LINE_COUNT(LC), .MAX_WR_STREAK(4)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .lookup_valid_i(lookup_valid), .lookup_ready_o(lookup_ready), .lookup_addr_i(lookup_addr),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .write_valid_i(write_valid), .write_ready_o(write_ready),
    .write_addr_i(write_addr), .write_set_i(write_set), .write_data_i(write_data),
    .ram_enable_o(ram_enable), .ram_write_o(ram_write), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  function automatic logic [LW-1:0] line(input int s, input int a);
    return {16'hBEEF, 8'(s), 8'(a), 96'h0123_4567_89AB_CDEF_0011_2233};
  endfunction

  function automatic logic [DW-1:0] row(input int a);
    logic [DW-1:0] r;
    for (int s = 0; s < SC; s++) r[s*LW +: LW] = line(s, a);
    return r;
  endfunction

  // SRAM model: preloaded pattern overlaid by writes; a write scrambles the
  // read port so stale-direct data is distinguishable from buffered data.
  bit            wmask [SC][LC];
  logic [LW-1:0] wmem  [SC][LC];
  always @(posedge clk) begin
    if (ram_write) begin
      for (int s = 0; s < SC; s++) begin
        if (ram_enable[s]) begin
          wmem[s][ram_addr]  <= ram_wdata[s*LW +: LW];
          wmask[s][ram_addr] <= 1'b1;
        end
      end
      ram_rdata <= ~ram_rdata;
    end else if (|ram_enable) begin
      for (int s = 0; s < SC; s++) begin
        ram_rdata[s*LW +: LW] <= wmask[s][ram_addr] ? wmem[s][ram_addr] : line(s, int'(ram_addr));
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_data(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    int w;
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      w = 0;
      for (int s = SC - 1; s >= 0; s--) if (act[s*LW +: LW] !== exp[s*LW +: LW]) w = s;
      $display("FAIL %s: way %0d got %h expected %h", nm, w, act[w*LW +: LW], exp[w*LW +: LW]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       lv;
    logic [6:0] la;
    logic       wv;
    logic [6:0] wa;
    logic [2:0] ws;
    logic       rr;
    logic       lr;
    logic       wr;
    logic [7:0] en;
    logic       we;
    logic [6:0] addr;
    logic       rv;
  } vec_t;

  function automatic vec_t mk(input logic lv, input logic [6:0] la, input logic wv,
                              input logic [6:0] wa, input logic [2:0] ws, input logic rr,
                              input logic lr, input logic wr, input logic [7:0] en,
                              input logic we, input logic [6:0] addr, input logic rv);
    vec_t v;
    v.lv = lv; v.la = la; v.wv = wv; v.wa = wa; v.ws = ws; v.rr = rr;
    v.lr = lr; v.wr = wr; v.en = en; v.we = we; v.addr = addr; v.rv = rv;
    return v;
  endfunction

  localparam int NV = 22;
  vec_t tbl [NV];

  initial begin
    logic [DW-1:0] exp_row;

    //               lv la     wv wa     ws rr | lr wr en     we addr   rv
    tbl[0]  = mk(0, 7'h00, 0, 7'h00, 0, 1,   1, 1, 8'h00, 0, 7'h00, 0); // idle
    tbl[1]  = mk(1, 7'h05, 0, 7'h00, 0, 1,   1, 1, 8'hFF, 0, 7'h05, 0); // read only
    tbl[2]  = mk(0, 7'h00, 1, 7'h10, 2, 1,   0, 1, 8'h04, 1, 7'h10, 1); // write, rsp out
    tbl[3]  = mk(0, 7'h00, 1, 7'h11, 5, 0,   0, 1, 8'h20, 1, 7'h11, 0);
    tbl[4]  = mk(1, 7'h07, 1, 7'h12, 0, 1,   0, 1, 8'h01, 1, 7'h12, 0); // streak 0
    tbl[5]  = mk(1, 7'h07, 1, 7'h12, 0, 1,   0, 1, 8'h01, 1, 7'h12, 0); // streak 1
    tbl[6]  = mk(1, 7'h07, 1, 7'h12, 0, 1,   0, 1, 8'h01, 1, 7'h12, 0); // streak 2
    tbl[7]  = mk(1, 7'h07, 1, 7'h12, 0, 1,   0, 1, 8'h01, 1, 7'h12, 0); // streak 3
    tbl[8]  = mk(1, 7'h07, 1, 7'h12, 0, 1,   1, 0, 8'hFF, 0, 7'h07, 0); // streak 4 -> read
    tbl[9]  = mk(1, 7'h09, 0, 7'h00, 0, 0,   0, 1, 8'h00, 0, 7'h00, 1); // stall, no read
    tbl[10] = mk(1, 7'h09, 0, 7'h00, 0, 1,   1, 1, 8'hFF, 0, 7'h09, 1); // drain + new read
    tbl[11] = mk(0, 7'h00, 0, 7'h00, 0, 1,   1, 1, 8'h00, 0, 7'h00, 1);
    tbl[12] = mk(0, 7'h00, 0, 7'h00, 0, 1,   1, 1, 8'h00, 0, 7'h00, 0);
    tbl[13] = mk(1, 7'h07, 1, 7'h12, 0, 1,   0, 1, 8'h01, 1, 7'h12, 0); // streak 0
    tbl[14] = mk(1, 7'h07, 1, 7'h12, 0, 1,   0, 1, 8'h01, 1, 7'h12, 0); // streak 1
    tbl[15] = mk(0, 7'h07, 1, 7'h12, 0, 1,   0, 1, 8'h01, 1, 7'h12, 0); // lookup gap clears
    tbl[16] = mk(1, 7'h07, 1, 7'h12, 0, 1,   0, 1, 8'h01, 1, 7'h12, 0);
    tbl[17] = mk(1, 7'h07, 1, 7'h12, 0, 1,   0, 1, 8'h01, 1, 7'h12, 0);
    tbl[18] = mk(1, 7'h07, 1, 7'h12, 0, 1,   0, 1, 8'h01, 1, 7'h12, 0);
    tbl[19] = mk(1, 7'h07, 1, 7'h12, 0, 1,   0, 1, 8'h01, 1, 7'h12, 0);
    tbl[20] = mk(1, 7'h07, 1, 7'h12, 0, 1,   1, 0, 8'hFF, 0, 7'h07, 0);
    tbl[21] = mk(0, 7'h00, 0, 7'h00, 0, 1,   1, 1, 8'h00, 0, 7'h00, 1);

    // reset state, with both requesters pushing
    rst_i = 1'b1;
    lookup_valid = 1'b1; lookup_addr = 7'h05;
    write_valid = 1'b1; write_addr = 7'h10; write_set = 3'd1;
    write_data = {8{16'hDEAD}}; rsp_ready = 1'b1;
    #1;
    chk("reset_pins", {lookup_ready, write_ready, ram_enable, ram_write, rsp_valid},
        {1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
    chk_data("reset_rsp_data", rsp_data, ram_rdata);
    tick();
    tick();
    chk("reset_hold", {lookup_ready, write_ready, ram_enable, ram_write, rsp_valid}, '0);
    lookup_valid = 1'b0; write_valid = 1'b0;
    rst_i = 1'b0;
    #1;
    chk("post_reset_idle", {ram_enable, ram_write, ram_addr, rsp_valid}, '0);
    tick();

    // arbitration / streak table
    for (int i = 0; i < NV; i++) begin
      lookup_valid = tbl[i].lv; lookup_addr = tbl[i].la;
      write_valid  = tbl[i].wv; write_addr  = tbl[i].wa; write_set = tbl[i].ws;
      rsp_ready    = tbl[i].rr;
      #2;
      chk($sformatf("vec%0d", i),
          {lookup_ready, write_ready, ram_enable, ram_write, ram_addr, rsp_valid},
          {tbl[i].lr, tbl[i].wr, tbl[i].en, tbl[i].we, tbl[i].addr, tbl[i].rv});
      tick();
    end
    lookup_valid = 1'b0; write_valid = 1'b0; rsp_ready = 1'b1;
    tick();

    // read 0x05 then back-to-back 0x06..0x08
    lookup_valid = 1'b1; lookup_addr = 7'h05;
    #2;
    chk("rd5_pins", {ram_enable, ram_write, ram_addr}, {8'hFF, 1'b0, 7'h05});
    tick();
    for (int k = 6; k <= 8; k++) begin
      lookup_addr = 7'(k);
      #2;
      chk($sformatf("b2b_valid%0d", k - 1), rsp_valid, 1'b1);
      chk_data($sformatf("b2b_data%0d", k - 1), rsp_data, row(k - 1));
      chk($sformatf("b2b_pins%0d", k), {ram_enable, ram_addr}, {8'hFF, 7'(k)});
      tick();
    end
    lookup_valid = 1'b0;
    #2;
    chk("b2b_valid8", rsp_valid, 1'b1);
    chk_data("b2b_data8", rsp_data, row(8));
    tick();
    #2;
    chk("b2b_done", rsp_valid, 1'b0);
    tick();

    // refill write of 0x7F way 3, then read it back
    write_valid = 1'b1; write_addr = 7'h7F; write_set = 3'd3; write_data = {16{8'hA5}};
    #2;
    chk("wr7f_pins", {write_ready, ram_enable, ram_write, ram_addr}, {1'b1, 8'h08, 1'b1, 7'h7F});
    chk_data("wr7f_wdata", ram_wdata, {SC{write_data}});
    tick();
    write_valid = 1'b0; lookup_valid = 1'b1; lookup_addr = 7'h7F;
    #2;
    chk("rd7f_pins", {ram_enable, ram_write, ram_addr}, {8'hFF, 1'b0, 7'h7F});
    tick();
    lookup_valid = 1'b0;
    exp_row = row(127);
    exp_row[3*LW +: LW] = {16{8'hA5}};
    #2;
    chk("rd7f_valid", rsp_valid, 1'b1);
    chk_data("rd7f_data", rsp_data, exp_row);
    tick();

    // backpressure: read 0x20 stalled 3 cycles, write to 0x20 during stall
    lookup_valid = 1'b1; lookup_addr = 7'h20; rsp_ready = 1'b0;
    #2;
    chk("bp_grant", {lookup_ready, ram_enable}, {1'b1, 8'hFF});
    tick();
    write_valid = 1'b1; write_addr = 7'h20; write_set = 3'd1; write_data = {16{8'h5A}};
    #2;
    chk("bp_n1_pins", {rsp_valid, lookup_ready, write_ready, ram_enable, ram_write},
        {1'b1, 1'b0, 1'b1, 8'h02, 1'b1});
    chk_data("bp_n1_data", rsp_data, row(32));
    tick();
    write_valid = 1'b0;
    for (int c = 2; c <= 3; c++) begin
      #2;
      chk($sformatf("bp_n%0d_pins", c), {rsp_valid, lookup_ready, ram_enable}, {1'b1, 1'b0, 8'h00});
      chk_data($sformatf("bp_n%0d_data", c), rsp_data, row(32));
      tick();
    end
    lookup_valid = 1'b0; rsp_ready = 1'b1;
    #2;
    chk("bp_release_valid", rsp_valid, 1'b1);
    chk_data("bp_release_data", rsp_data, row(32));
    tick();
    #2;
    chk("bp_drained", rsp_valid, 1'b0);
    lookup_valid = 1'b1; lookup_addr = 7'h20;
    tick();
    lookup_valid = 1'b0;
    exp_row = row(32);
    exp_row[1*LW +: LW] = {16{8'h5A}};
    #2;
    chk("bp_new_valid", rsp_valid, 1'b1);
    chk_data("bp_new_data", rsp_data, exp_row);
    tick();

    // reset the cycle after a read grant
    lookup_valid = 1'b1; lookup_addr = 7'h05;
    #2;
    chk("rst_pre_grant", ram_enable, 8'hFF);
    tick();
    rst_i = 1'b1; write_valid = 1'b1;
    #1;
    chk("rst_mid_pins", {lookup_ready, write_ready, ram_enable, ram_write, rsp_valid}, '0);
    tick();
    chk("rst_mid_hold", rsp_valid, 1'b0);
    rst_i = 1'b0; lookup_valid = 1'b0; write_valid = 1'b0;
    #2;
    chk("rst_after0", rsp_valid, 1'b0);
    tick();
    #2;
    chk("rst_after1", rsp_valid, 1'b0);
    lookup_valid = 1'b1; lookup_addr = 7'h05;
    #1;
    chk("rst_rd_pins", {ram_enable, ram_write, ram_addr}, {8'hFF, 1'b0, 7'h05});
    tick();
    lookup_valid = 1'b0;
    #2;
    chk("rst_rd_valid", rsp_valid, 1'b1);
    chk_data("rst_rd_data", rsp_data, row(5));
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
